sdram_model: RTL and testbench

Synthesizable single-clock responder for the board's 16-bit SDR SDRAM bus. It decodes the command pins driven by the CPU's SDRAM controller, tracks per-bank open rows and the mode register, stores write bursts and returns read bursts after the programmed CAS latency. It also raises sticky protocol-violation flags. It sits in simulation and loopback benches in place of the physical chip, on the device side of `sdram_d_out`/`sdram_d_en`/`sdram_d_in`.

---
 rtl/sdram_pkg.sv | 58 +++++
 rtl/sdram_read_pipe.sv | 55 +++++
 rtl/sdram_model.sv | 218 +++++++++++++++++++++
 tb/tb_sdram_model.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared types for the SDR SDRAM device model: command decode, mode register layout,
// read-pipeline beat record and error flag positions.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_RD,
    CMD_WR,
    CMD_PRE,
    CMD_REF,
    CMD_LMR,
    CMD_BST
  } cmd_e;

  // bl is log2 of the burst length; cl is the CAS latency in cycles (2 or 3)
  typedef struct packed {
    logic [1:0] bl;
    logic [1:0] cl;
    logic       wbs;
  } mode_t;

  typedef struct packed {
    logic        valid;
    logic        cl3;
    logic [1:0]  mask;
    logic [15:0] data;
  } rd_beat_t;

  localparam mode_t MODE_RESET = '{bl: 2'd0, cl: 2'd2, wbs: 1'b0};

  localparam int unsigned ERR_CLOSED  = 0;
  localparam int unsigned ERR_REOPEN  = 1;
  localparam int unsigned ERR_NOMODE  = 2;
  localparam int unsigned ERR_REFOPEN = 3;
  localparam int unsigned ERR_MODE    = 4;
  localparam int unsigned ERR_COLLIDE = 5;

  function automatic cmd_e decode_cmd(input logic csn, input logic rasn, input logic casn,
                                      input logic wen);
    cmd_e cmd;
    cmd = CMD_NOP;
    if (!csn) begin
      case ({rasn, casn, wen})
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_LMR;
        3'b110:  cmd = CMD_BST;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sdram_read_pipe.sv
// Read-data delay line: beats enter at fetch, leave through a registered output after their
// own CAS latency, with byte masks picked up two cycles before delivery.
module sdram_read_pipe
  import sdram_pkg::*;
(
  input  logic        clk_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic        cl3_i,
  input  logic [15:0] data_i,
  input  logic [1:0]  dqm_i,
  output logic        valid_o,
  output logic [15:0] data_o
);

  rd_beat_t [2:0] stage_q, stage_d;
  rd_beat_t       tap;
  logic           valid_d, valid_q;
  logic [15:0]    data_d, data_q;

  always_comb begin
    // The stage two edges ahead of the output register takes the current dqm
    stage_d[0] = '{valid: valid_i, cl3: cl3_i, mask: (cl3_i ? 2'b00 : dqm_i), data: data_i};
    stage_d[1] = stage_q[0];
    if (stage_q[0].cl3) begin
      stage_d[1].mask = dqm_i;
    end
    stage_d[2] = stage_q[1];

    tap = '0;
    if (stage_q[1].valid && !stage_q[1].cl3) begin
      tap = stage_q[1];
    end else if (stage_q[2].valid && stage_q[2].cl3) begin
      tap = stage_q[2];
    end
    valid_d = tap.valid;
    data_d  = tap.data & {{8{~tap.mask[1]}}, {8{~tap.mask[0]}}};
  end

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      stage_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/sdram_model.sv
// Behavioural-but-synthesizable SDR SDRAM device: bank/row tracking, mode register,
// write/read bursts with CAS latency, and sticky protocol-violation flags.
module sdram_model
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_W      = 13,
  parameter int unsigned COL_W      = 9,
  parameter int unsigned MEM_ADDR_W = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sdram_csn,
  input  logic             sdram_rasn,
  input  logic             sdram_casn,
  input  logic             sdram_wen,
  input  logic [ROW_W-1:0] sdram_a,
  input  logic [1:0]       sdram_ba,
  input  logic [1:0]       sdram_dqm,
  input  logic [15:0]      sdram_d_out,
  input  logic             sdram_d_en,
  output logic [15:0]      sdram_d_in,
  output logic             q_en,
  output logic [5:0]       err,
  output logic [15:0]      refresh_cnt
);

  cmd_e                  cmd;
  mode_t                 mode_q, mode_d, eff_mode;
  logic                  mode_valid_q, mode_valid_d;
  logic [3:0]            open_q, open_d;
  logic [3:0][ROW_W-1:0] row_q, row_d;
  logic [5:0]            err_q, err_d;
  logic [15:0]           ref_cnt_q, ref_cnt_d;

  logic                  bst_act_q, bst_act_d, bst_wr_q, bst_wr_d;
  logic                  bst_cl3_q, bst_cl3_d, bst_ap_q, bst_ap_d;
  logic [1:0]            bst_ba_q, bst_ba_d, bst_bl_q, bst_bl_d;
  logic [ROW_W-1:0]      bst_row_q, bst_row_d;
  logic [COL_W-1:0]      bst_col_q, bst_col_d;
  logic [2:0]            bst_beat_q, bst_beat_d;

  logic                  rw_cmd, rw_go, bst_kill, bst_step, bst_last;
  logic [2:0]            last_beat;
  logic [1:0]            new_bl;
  logic [COL_W-1:0]      blk_mask, beat_col;
  logic                  acc_en, acc_wr, acc_cl3;
  logic [1:0]            acc_ba;
  logic [ROW_W-1:0]      acc_row;
  logic [COL_W-1:0]      acc_col;
  logic [MEM_ADDR_W-1:0] mem_idx;
  logic [15:0]           mem_q [2**MEM_ADDR_W];

  // Command decode and selection of this cycle's single store access
  always_comb begin
    cmd       = decode_cmd(sdram_csn, sdram_rasn, sdram_casn, sdram_wen);
    eff_mode  = mode_valid_q ? mode_q : MODE_RESET;
    rw_cmd    = (cmd == CMD_RD) || (cmd == CMD_WR);
    rw_go     = rw_cmd && open_q[sdram_ba];
    bst_kill  = rw_go || (cmd == CMD_BST) ||
                ((cmd == CMD_PRE) && (sdram_a[10] || (sdram_ba == bst_ba_q)));
    bst_step  = bst_act_q && !bst_kill;
    last_beat = 3'((4'd1 << bst_bl_q) - 4'd1);
    bst_last  = (bst_beat_q == last_beat);
    blk_mask  = ~({COL_W{1'b1}} << bst_bl_q);
    beat_col  = (bst_col_q & ~blk_mask) | ((bst_col_q + COL_W'(bst_beat_q)) & blk_mask);

    acc_en  = 1'b0;
    acc_wr  = 1'b0;
    acc_cl3 = 1'b0;
    acc_ba  = sdram_ba;
    acc_row = row_q[sdram_ba];
    acc_col = sdram_a[COL_W-1:0];
    if (rw_go) begin
      acc_en  = 1'b1;
      acc_wr  = (cmd == CMD_WR);
      acc_cl3 = (eff_mode.cl == 2'd3);
    end else if (bst_step) begin
      acc_en  = 1'b1;
      acc_wr  = bst_wr_q;
      acc_cl3 = bst_cl3_q;
      acc_ba  = bst_ba_q;
      acc_row = bst_row_q;
      acc_col = beat_col;
    end
    mem_idx = MEM_ADDR_W'({acc_ba, acc_row, acc_col});
  end

  always_comb begin
    mode_d       = mode_q;
    mode_valid_d = mode_valid_q;
    open_d       = open_q;
    row_d        = row_q;
    err_d        = err_q;
    ref_cnt_d    = ref_cnt_q;
    bst_act_d    = bst_act_q;
    bst_wr_d     = bst_wr_q;
    bst_cl3_d    = bst_cl3_q;
    bst_ap_d     = bst_ap_q;
    bst_ba_d     = bst_ba_q;
    bst_bl_d     = bst_bl_q;
    bst_row_d    = bst_row_q;
    bst_col_d    = bst_col_q;
    bst_beat_d   = bst_beat_q;
    new_bl       = (cmd == CMD_WR && eff_mode.wbs) ? 2'd0 : eff_mode.bl;

    if (rw_go) begin
      bst_act_d  = (new_bl != 2'd0);
      bst_wr_d   = (cmd == CMD_WR);
      bst_cl3_d  = (eff_mode.cl == 2'd3);
      bst_ap_d   = sdram_a[10];
      bst_ba_d   = sdram_ba;
      bst_bl_d   = new_bl;
      bst_row_d  = row_q[sdram_ba];
      bst_col_d  = sdram_a[COL_W-1:0];
      bst_beat_d = 3'd1;
      if (new_bl == 2'd0 && sdram_a[10]) begin
        open_d[sdram_ba] = 1'b0;
      end
    end else if (bst_kill) begin
      bst_act_d = 1'b0;
    end else if (bst_act_q) begin
      bst_beat_d = bst_beat_q + 3'd1;
      if (bst_last) begin
        bst_act_d = 1'b0;
        if (bst_ap_q) begin
          open_d[bst_ba_q] = 1'b0;
        end
      end
    end

    if (rw_cmd && !open_q[sdram_ba]) err_d[ERR_CLOSED] = 1'b1;
    if (rw_go && !mode_valid_q)      err_d[ERR_NOMODE] = 1'b1;
    if (sdram_d_en && q_en)          err_d[ERR_COLLIDE] = 1'b1;

    case (cmd)
      CMD_ACT: begin
        if (open_q[sdram_ba]) err_d[ERR_REOPEN] = 1'b1;
        open_d[sdram_ba] = 1'b1;
        row_d[sdram_ba]  = sdram_a;
      end
      CMD_PRE: begin
        if (sdram_a[10]) open_d = '0;
        else             open_d[sdram_ba] = 1'b0;
      end
      CMD_REF: begin
        ref_cnt_d = ref_cnt_q + 16'd1;
        if (|open_q) err_d[ERR_REFOPEN] = 1'b1;
      end
      CMD_LMR: begin
        mode_valid_d = 1'b1;
        mode_d.bl    = sdram_a[2] ? 2'd0 : sdram_a[1:0];
        mode_d.cl    = (sdram_a[6:4] == 3'd3) ? 2'd3 : 2'd2;
        mode_d.wbs   = sdram_a[9];
        if (sdram_a[2] || sdram_a[3] || (sdram_a[6:5] != 2'b01)) err_d[ERR_MODE] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q       <= MODE_RESET;
      mode_valid_q <= 1'b0;
      open_q       <= '0;
      row_q        <= '0;
      err_q        <= '0;
      ref_cnt_q    <= '0;
      bst_act_q    <= 1'b0;
      bst_wr_q     <= 1'b0;
      bst_cl3_q    <= 1'b0;
      bst_ap_q     <= 1'b0;
      bst_ba_q     <= '0;
      bst_bl_q     <= '0;
      bst_row_q    <= '0;
      bst_col_q    <= '0;
      bst_beat_q   <= '0;
    end else begin
      mode_q       <= mode_d;
      mode_valid_q <= mode_valid_d;
      open_q       <= open_d;
      row_q        <= row_d;
      err_q        <= err_d;
      ref_cnt_q    <= ref_cnt_d;
      bst_act_q    <= bst_act_d;
      bst_wr_q     <= bst_wr_d;
      bst_cl3_q    <= bst_cl3_d;
      bst_ap_q     <= bst_ap_d;
      bst_ba_q     <= bst_ba_d;
      bst_bl_q     <= bst_bl_d;
      bst_row_q    <= bst_row_d;
      bst_col_q    <= bst_col_d;
      bst_beat_q   <= bst_beat_d;
    end
  end

  // Store contents survive reset
  always_ff @(posedge CLK) begin
    if (!RST && acc_en && acc_wr) begin
      if (!sdram_dqm[0]) mem_q[mem_idx][7:0]  <= sdram_d_out[7:0];
      if (!sdram_dqm[1]) mem_q[mem_idx][15:8] <= sdram_d_out[15:8];
    end
  end

  sdram_read_pipe u_read_pipe (
    .clk_i   (CLK),
    .flush_i (RST),
    .valid_i (acc_en && !acc_wr),
    .cl3_i   (acc_cl3),
    .data_i  (mem_q[mem_idx]),
    .dqm_i   (sdram_dqm),
    .valid_o (q_en),
    .data_o  (sdram_d_in)
  );

  assign err         = err_q;
  assign refresh_cnt = ref_cnt_q;

endmodule

// File: tb/tb_sdram_model.sv
// Directed bench for sdram_model: a per-cycle vector table for burst data/latency, then
// hand sequences for error flags, collision and reset.
module tb_sdram_model;

  localparam logic [2:0] NOP = 3'b111;
  localparam logic [2:0] ACT = 3'b011;
  localparam logic [2:0] RD  = 3'b101;
  localparam logic [2:0] WR  = 3'b100;
  localparam logic [2:0] REF = 3'b001;
  localparam logic [2:0] LMR = 3'b000;
  localparam logic [2:0] BST = 3'b110;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sdram_csn, sdram_rasn, sdram_casn, sdram_wen;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba, sdram_dqm;
  logic [15:0] sdram_d_out, sdram_d_in, refresh_cnt;
  logic        sdram_d_en, q_en;
  logic [5:0]  err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  rcw;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [1:0]  dqm;
    logic [15:0] dout;
    logic        exp_qen;
    logic [15:0] exp_din;
  } vec_t;

  vec_t vecs[$];

  sdram_model dut (
    .CLK         (CLK),
    .RST         (RST),
    .sdram_csn   (sdram_csn),
    .sdram_rasn  (sdram_rasn),
    .sdram_casn  (sdram_casn),
    .sdram_wen   (sdram_wen),
    .sdram_a     (sdram_a),
    .sdram_ba    (sdram_ba),
    .sdram_dqm   (sdram_dqm),
    .sdram_d_out (sdram_d_out),
    .sdram_d_en  (sdram_d_en),
    .sdram_d_in  (sdram_d_in),
    .q_en        (q_en),
    .err         (err),
    .refresh_cnt (refresh_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] dout);
    sdram_csn = 1'b0;
    {sdram_rasn, sdram_casn, sdram_wen} = rcw;
    sdram_ba    = ba;
    sdram_a     = a;
    sdram_dqm   = dqm;
    sdram_d_out = dout;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [2:0] rcw, input logic [1:0] ba, input logic [12:0] a,
                     input logic [1:0] dqm, input logic [15:0] dout, input logic eq,
                     input logic [15:0] ed);
    vec_t v;
    v.rcw = rcw; v.ba = ba; v.a = a; v.dqm = dqm; v.dout = dout;
    v.exp_qen = eq; v.exp_din = ed;
    vecs.push_back(v);
  endtask

  initial begin
    drive(NOP, 2'd0, 13'd0, 2'b00, 16'h0);
    sdram_d_en = 1'b0;
    RST = 1'b1;
    tick;
    tick;
    RST = 1'b0;
    check("reset q_en", 32'(q_en), 32'd0);
    check("reset d_in", 32'(sdram_d_in), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset refresh_cnt", 32'(refresh_cnt), 32'd0);

    // Basic BL4/CL2 write then wrapped read from col 6
    add(LMR, 2'd0, 13'h022, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(ACT, 2'd1, 13'h005, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(WR,  2'd1, 13'h004, 2'b00, 16'h1111, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h2222, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h3333, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h4444, 1'b0, 16'h0);
    add(RD,  2'd1, 13'h006, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h3333);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h4444);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h1111);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h2222);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    // BL2/CL3: masked write, masked read beat 0, then back-to-back unmasked read
    add(LMR, 2'd0, 13'h031, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(WR,  2'd1, 13'h010, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(WR,  2'd1, 13'h010, 2'b10, 16'hABCD, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h5678, 1'b0, 16'h0);
    add(RD,  2'd1, 13'h010, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b01, 16'h0000, 1'b0, 16'h0);
    add(RD,  2'd1, 13'h010, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0000);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h5678);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h00CD);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h5678);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    // BL8/CL2: fill cols 0..7, terminate after 4 beats, then interrupt with a new READ
    add(LMR, 2'd0, 13'h023, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(WR,  2'd1, 13'h000, 2'b00, 16'h0100, 1'b0, 16'h0);
    for (int k = 1; k < 8; k++) add(NOP, 2'd0, 13'h000, 2'b00, 16'h0100 + 16'(k), 1'b0, 16'h0);
    add(RD,  2'd1, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0100);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0101);
    add(BST, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0102);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0103);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(RD,  2'd1, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);
    add(RD,  2'd1, 13'h004, 2'b00, 16'h0000, 1'b1, 16'h0100);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0101);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0104);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0105);
    add(BST, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0106);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b1, 16'h0107);
    add(NOP, 2'd0, 13'h000, 2'b00, 16'h0000, 1'b0, 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rcw, vecs[i].ba, vecs[i].a, vecs[i].dqm, vecs[i].dout);
      tick;
      check($sformatf("vec%0d q_en", i), 32'(q_en), 32'(vecs[i].exp_qen));
      if (vecs[i].exp_qen) begin
        check($sformatf("vec%0d d_in", i), 32'(sdram_d_in), 32'(vecs[i].exp_din));
      end
    end
    check("table err clean", 32'(err), 32'd0);

    // Collision during read delivery, then reset with beats in flight
    drive(RD, 2'd1, 13'h000, 2'b00, 16'h0);
    tick;
    drive(NOP, 2'd0, 13'h000, 2'b00, 16'h0);
    tick;
    tick;
    check("read q_en before collide", 32'(q_en), 32'd1);
    sdram_d_en = 1'b1;
    tick;
    sdram_d_en = 1'b0;
    check("collision err", 32'(err), 32'h20);
    RST = 1'b1;
    tick;
    RST = 1'b0;
    check("midburst reset q_en", 32'(q_en), 32'd0);
    check("midburst reset d_in", 32'(sdram_d_in), 32'd0);
    check("midburst reset err", 32'(err), 32'd0);

    // Protocol violations
    drive(RD, 2'd0, 13'h000, 2'b00, 16'h0);
    tick;
    check("closed read err", 32'(err), 32'h01);
    drive(NOP, 2'd0, 13'h000, 2'b00, 16'h0);
    tick;
    tick;
    check("closed read no q_en", 32'(q_en), 32'd0);
    tick;
    check("closed read no q_en late", 32'(q_en), 32'd0);
    drive(ACT, 2'd2, 13'h007, 2'b00, 16'h0);
    tick;
    check("single activate err", 32'(err), 32'h01);
    tick;
    check("reopen err", 32'(err), 32'h03);
    drive(REF, 2'd0, 13'h000, 2'b00, 16'h0);
    tick;
    check("refresh open err", 32'(err), 32'h0B);
    check("refresh count", 32'(refresh_cnt), 32'd1);

    // Access before LOAD MODE, then an unsupported mode coerced to BL1/CL2
    RST = 1'b1;
    drive(NOP, 2'd0, 13'h000, 2'b00, 16'h0);
    tick;
    RST = 1'b0;
    drive(ACT, 2'd0, 13'h003, 2'b00, 16'h0);
    tick;
    drive(WR, 2'd0, 13'h007, 2'b00, 16'hBEEF);
    tick;
    check("no mode err", 32'(err), 32'h04);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        drive(LMR, 2'd0, 13'h004, 2'b00, 16'h0);
        tick;
        check("bad mode err", 32'(err), 32'h14);
      end
      drive(NOP, 2'd0, 13'h000, 2'b00, 16'h1234);
      tick;
      drive(RD, 2'd0, 13'h007, 2'b00, 16'h0);
      tick;
      drive(NOP, 2'd0, 13'h000, 2'b00, 16'h0);
      tick;
      check($sformatf("bl1 read%0d pre q_en", pass), 32'(q_en), 32'd0);
      tick;
      check($sformatf("bl1 read%0d q_en", pass), 32'(q_en), 32'd1);
      check($sformatf("bl1 read%0d d_in", pass), 32'(sdram_d_in), 32'h0000BEEF);
      tick;
      check($sformatf("bl1 read%0d end q_en", pass), 32'(q_en), 32'd0);
    end
    check("final err", 32'(err), 32'h14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
